gf2_31_mul_ds: RTL and testbench

//   Digit-serial GF(2^31) multiplier: c(x) = a(x)*b(x) mod h(x), h(x) = x^31+x^13+x^8+x^3+1.

---
 rtl/gf2_31_pkg.sv | 29 ++
 rtl/gf2_31_mul_ds_step.sv | 31 +++
 rtl/gf2_31_mul_ds.sv | 178 +++++++++++++++++
 tb/tb_gf2_31_mul_ds.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_31_pkg.sv
// Shared constants, FSM state type and reduction helper for the digit-serial GF(2^31) multiplier.
package gf2_31_pkg;

  localparam int M     = 31;
  localparam int D     = 4;
  localparam int N_DIG = (M + D - 1) / D;
  localparam int B_W   = N_DIG * D;
  localparam int CNT_W = $clog2(N_DIG);

  // h(x) = x^31 + x^13 + x^8 + x^3 + 1, stored without the x^M term
  localparam logic [M-1:0] H_POLY = 31'h0000_2109;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Fold an (M+D)-bit word back to M bits; valid while deg(H_POLY) + D - 1 < M.
  function automatic logic [M-1:0] red_poly(input logic [M+D-1:0] v);
    logic [M-1:0] r;
    r = v[M-1:0];
    for (int k = 0; k < D; k++) begin
      r = r ^ ((H_POLY & {M{v[M+k]}}) << k);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf2_31_mul_ds_step.sv
// One digit step of the multiplier: acc_next = red((acc << D) ^ clmul(a, dig)), purely combinational.
module gf2_mul_digit_step #(
  parameter int              M      = gf2_31_pkg::M,
  parameter int              D      = gf2_31_pkg::D,
  parameter logic [M-1:0]    H_POLY = gf2_31_pkg::H_POLY
) (
  input  logic [M-1:0] acc_i,
  input  logic [M-1:0] a_i,
  input  logic [D-1:0] dig_i,
  output logic [M-1:0] acc_next_o
);

  logic [M+D-1:0] wide_s;

  // Shifted accumulator XOR the D-bit x M-bit carry-less partial products
  always_comb begin
    wide_s = {acc_i, {D{1'b0}}};
    for (int j = 0; j < D; j++) begin
      wide_s = wide_s ^ (({{D{1'b0}}, a_i} & {(M + D){dig_i[j]}}) << j);
    end
  end

  // Bits M..M+D-1 map onto x^k * h_low(x); one fold suffices for a low-degree h
  always_comb begin
    acc_next_o = wide_s[M-1:0];
    for (int k = 0; k < D; k++) begin
      acc_next_o = acc_next_o ^ ((H_POLY & {M{wide_s[M+k]}}) << k);
    end
  end

endmodule

// File: rtl/gf2_31_mul_ds.sv
// Digit-serial GF(2^31) multiplier with valid/ready on both sides, one operation in flight.
// Optional build macro GF2_MUL_ZERO_BYPASS_EN: a zero operand goes straight to DONE with out_c = 0.
module gf2_31_mul_ds
  import gf2_31_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_c
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIG - 1);

  state_e           state_q, state_d;
  logic [M-1:0]     a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [M-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [M-1:0]     out_c_q, out_c_d;
  logic [1:0]       rst_sync_q, rst_sync_d;

  logic             rst_done_s;
  logic             accept_s;
  logic [M-1:0]     acc_next_s;
`ifdef GF2_MUL_ZERO_BYPASS_EN
  logic             zero_op_s;
`endif

  // Reset asserts asynchronously; handshakes stay blocked until release has crossed two flops
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset release synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_done_s = rst_sync_q[1];
  assign accept_s   = in_valid & in_ready_q & rst_done_s;
`ifdef GF2_MUL_ZERO_BYPASS_EN
  assign zero_op_s  = (in_a == {M{1'b0}}) | (in_b == {M{1'b0}});
`endif

  gf2_mul_digit_step #(
    .M      (M),
    .D      (D),
    .H_POLY (H_POLY)
  ) u_step (
    .acc_i      (acc_q),
    .a_i        (a_q),
    .dig_i      (b_q[B_W-1 -: D]),
    .acc_next_o (acc_next_s)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= {M{1'b0}};
      b_q         <= {B_W{1'b0}};
      acc_q       <= {M{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_c_q     <= {M{1'b0}};
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
`ifdef GF2_MUL_ZERO_BYPASS_EN
          if (zero_op_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
`else
          state_d = ST_BUSY;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state; b shifts left so its top digit is always current
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_c_d     = out_c_q;
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          a_d   = in_a;
          b_d   = {{(B_W - M){1'b0}}, in_b};
          acc_d = {M{1'b0}};
          cnt_d = {CNT_W{1'b0}};
`ifdef GF2_MUL_ZERO_BYPASS_EN
          if (zero_op_s) begin
            out_c_d = {M{1'b0}};
          end else begin
            out_c_d = out_c_q;
          end
`endif
        end else begin
          a_d = a_q;
        end
      end
      ST_BUSY: begin
        acc_d = acc_next_s;
        b_d   = b_q << D;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          out_c_d = acc_next_s;
        end else begin
          out_c_d = out_c_q;
        end
      end
      ST_DONE: begin
        out_c_d = out_c_q;
      end
      default: begin
        acc_d = {M{1'b0}};
        cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;

endmodule

// File: tb/tb_gf2_31_mul_ds.sv
// Self-checking bench for gf2_31_mul_ds: directed vectors, back-pressure, reset abort, zero operands,
// throughput and a randomised scoreboard against a bit-serial reference multiplier.
module tb_gf2_31_mul_ds;

  localparam logic [30:0] H_LOW    = 31'h0000_2109;
  localparam int          FULL_LAT = 9;  // edges counted from the accepting edge through out_valid
`ifdef GF2_MUL_ZERO_BYPASS_EN
  localparam int          ZERO_LAT = 1;
`else
  localparam int          ZERO_LAT = 9;
`endif
  localparam int          N_RAND   = 1500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [30:0] in_a = 31'h0;
  logic [30:0] in_b = 31'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [30:0] out_c;

  logic [30:0] exp_q[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  longint      cyc = 0;

  gf2_31_mul_ds dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: full 61-bit carry-less product, then clear the top bits one by one with h(x)
  function automatic logic [30:0] ref_mul(input logic [30:0] a, input logic [30:0] b);
    logic [61:0] p;
    p = 62'h0;
    for (int i = 0; i < 31; i++) if (b[i]) p = p ^ ({31'h0, a} << i);
    for (int i = 60; i >= 31; i--) if (p[i]) p = p ^ ({30'h0, 1'b1, H_LOW} << (i - 31));
    return p[30:0];
  endfunction

  task automatic start_op(input logic [30:0] a, input logic [30:0] b, output longint t_drive);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin @(posedge clk); #1; w++; end
    in_a = a; in_b = b; in_valid = 1'b1; t_drive = cyc;
    exp_q.push_back(ref_mul(a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    #12;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_c !== 31'h0) $display("FAIL rst_out_c got %h exp 0", out_c); else pass_cnt++;
    @(posedge clk); #3; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL rst_release got rdy=%b vld=%b exp 1/0", in_ready, out_valid); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [30:0] va[4];
    logic [30:0] vb[4];
    logic [30:0] ve[4];
    logic [30:0] exp;
    longint t;
    int lat;
    va = '{31'h4000_0000, 31'h4000_0000, 31'h1234_5678, 31'h0000_0001};
    vb = '{31'h0000_0002, 31'h4000_0000, 31'h0000_0001, 31'h1234_5678};
    ve = '{31'h0000_2109, 31'h2100_4852, 31'h1234_5678, 31'h1234_5678};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], t);
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL dir%0d_busy_ready got %b exp 0", i, in_ready); else pass_cnt++;
      wait_valid(lat);
      exp = exp_q.pop_front();
      chk_cnt++; if (lat != FULL_LAT) $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, FULL_LAT); else pass_cnt++;
      chk_cnt++; if (out_c !== ve[i] || exp !== ve[i]) $display("FAIL dir%0d_c got %h model %h exp %h", i, out_c, exp, ve[i]); else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [30:0] exp;
    longint t;
    int lat;
    bit seen;
    out_ready = 1'b0;
    start_op(31'h4000_0000, 31'h0000_0002, t);
    wait_valid(lat);
    exp = exp_q.pop_front();
    chk_cnt++; if (out_c !== exp) $display("FAIL bp_c got %h exp %h", out_c, exp); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 31'h3abc_def0; in_b = 31'h0000_0001;
      @(posedge clk); #1;
      chk_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_c !== exp)
        $display("FAIL bp_hold%0d got vld=%b rdy=%b c=%h exp 1/0/%h", i, out_valid, in_ready, out_c, exp);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got vld=%b rdy=%b exp 0/1", out_valid, in_ready); else pass_cnt++;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk_cnt++; if (seen) $display("FAIL bp_no_queue got out_valid=1 exp 0"); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [30:0] exp;
    longint t;
    int lat;
    bit seen;
    start_op(31'h4000_0000, 31'h4000_0000, t);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rmid_async got vld=%b rdy=%b exp 0/1", out_valid, in_ready); else pass_cnt++;
    exp_q.delete();
    @(posedge clk); #3; rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk_cnt++; if (seen) $display("FAIL rmid_dropped got out_valid=1 exp 0"); else pass_cnt++;
    start_op(31'h4000_0000, 31'h0000_0002, t);
    wait_valid(lat);
    exp = exp_q.pop_front();
    chk_cnt++; if (out_c !== 31'h0000_2109 || lat != FULL_LAT) $display("FAIL rmid_next got %h lat %0d exp 00002109 lat %0d", out_c, lat, FULL_LAT); else pass_cnt++;
    chk_cnt++; if (exp !== 31'h0000_2109) $display("FAIL rmid_model got %h exp 00002109", exp); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    logic [30:0] exp;
    longint t;
    int lat;
    start_op(31'h0000_0000, 31'h7fff_ffff, t);
    wait_valid(lat);
    exp = exp_q.pop_front();
    chk_cnt++; if (out_c !== 31'h0 || exp !== 31'h0) $display("FAIL zero_a_c got %h exp 0", out_c); else pass_cnt++;
    chk_cnt++; if (lat != ZERO_LAT) $display("FAIL zero_a_latency got %0d exp %0d", lat, ZERO_LAT); else pass_cnt++;
    @(posedge clk); #1;
    start_op(31'h5a5a_5a5a, 31'h0000_0000, t);
    wait_valid(lat);
    exp = exp_q.pop_front();
    chk_cnt++; if (out_c !== exp || lat != ZERO_LAT) $display("FAIL zero_b got %h lat %0d exp %h lat %0d", out_c, lat, exp, ZERO_LAT); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [30:0] exp;
    longint t_prev, t_now;
    int lat;
    out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      start_op(31'h0123_4567 + 31'(i), 31'h7654_3210 ^ 31'(i * 5), t_now);
      if (i > 0) begin
        chk_cnt++; if (t_now - t_prev != 10) $display("FAIL b2b_period%0d got %0d exp 10", i, t_now - t_prev); else pass_cnt++;
      end
      t_prev = t_now;
      wait_valid(lat);
      exp = exp_q.pop_front();
      chk_cnt++; if (out_c !== exp) $display("FAIL b2b_c%0d got %h exp %h", i, out_c, exp); else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [30:0] exp, held;
    longint t;
    int w, stable_bad;
    bit popped, done, hs;
    stable_bad = 0;
    held = 31'h0;
    for (int n = 0; n < N_RAND; n++) begin
      start_op(31'($urandom), 31'($urandom), t);
      popped = 1'b0; done = 1'b0; w = 0;
      while (!done && w < 200) begin
        if (out_valid && !popped) begin
          exp = exp_q.pop_front();
          chk_cnt++; if (out_c !== exp) $display("FAIL rand%0d_c got %h exp %h", n, out_c, exp); else pass_cnt++;
          popped = 1'b1; held = out_c;
        end else if (out_valid && out_c !== held) begin
          stable_bad++;
        end
        out_ready = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
        in_a = 31'($urandom); in_b = 31'($urandom);
        hs = out_valid && out_ready;
        @(posedge clk); #1; w++;
        if (hs) done = 1'b1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      if (!popped) begin
        chk_cnt++; $display("FAIL rand%0d_timeout got no out_valid exp result", n);
        exp_q.delete();
      end
    end
    chk_cnt++; if (stable_bad != 0) $display("FAIL rand_hold got %0d changes exp 0", stable_bad); else pass_cnt++;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL rand_queue got %0d left exp 0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
